// File: rtl/dl_pkg.sv
// Shared types and constants for the ROM/config download controller.
package dl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ROM,
      ROM_PEND,
      CFG,
      HOLD
   } dl_state_t;

   localparam logic [7:0]  IDX_ROM    = 8'd0;
   localparam logic [7:0]  IDX_MOD    = 8'd1;
   localparam logic [7:0]  IDX_DIP    = 8'd254;
   localparam logic [63:0] SW_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

   localparam int unsigned CNT_W = 17;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Byte counter increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/dl_hold_timer.sv
// Core-reset hold timer: busy stays high for exactly len cycles after the start edge.
module dl_hold_timer #(
   parameter int unsigned W = 10
) (
   input  logic         CLK,
   input  logic         start,
   input  logic [W-1:0] len,
   output logic         busy
);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (start) begin
         cnt  <= len;
         busy <= (len != '0);
      end else if (busy) begin
         cnt  <= cnt - W'(1);
         busy <= (cnt != W'(1));
      end
   end

endmodule

// File: rtl/dl_ctrl.sv
// Loader-to-ROM download controller with DIP/variant capture and core reset hold.
// Optional build macro DL_CHECKSUM_EN enables the rom_sum byte checksum.
module dl_ctrl
   import dl_pkg::*;
#(
   parameter logic [16:0] ROM_LEN     = 17'h10000,
   parameter int unsigned HOLD_CYCLES = 1024
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [15:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   input  logic        dn_ready,
   output logic [7:0]  mod,
   output logic [63:0] sw,
   output logic        core_reset,
   output logic        rom_ok,
   output logic        proto_err,
   output logic [15:0] rom_sum
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   // The FSM samples the registered busy flag, which adds the final hold cycle.
   localparam logic [HOLD_W-1:0] HOLD_LEN = HOLD_W'(HOLD_CYCLES - 1);

   dl_state_t        state;
   logic             dl_q;
   logic [CNT_W-1:0] byte_cnt;
   logic             hold_busy;

   logic             dl_rise_c;
   logic             rom_wr_c;
   logic             accept_c;
   logic             done_c;
   logic             hold_start_c;
   logic [CNT_W-1:0] cnt_inc_c;

   assign dl_rise_c    = ioctl_download & ~dl_q;
   assign rom_wr_c     = ioctl_wr && (ioctl_index == IDX_ROM) && (ioctl_addr < 25'(ROM_LEN));
   assign accept_c     = (state == ROM_PEND) && dn_ready;
   assign done_c       = ((state == ROM) || accept_c) && !ioctl_download;
   assign hold_start_c = RESET | done_c;
   assign cnt_inc_c    = sat_inc(byte_cnt);

   dl_hold_timer #(.W(HOLD_W)) u_hold (
      .CLK   (CLK),
      .start (hold_start_c),
      .len   (HOLD_LEN),
      .busy  (hold_busy)
   );

   always_ff @(posedge CLK) begin
      dl_q <= ioctl_download;
      if (RESET) begin
         state      <= HOLD;
         dn_wr      <= 1'b0;
         ioctl_wait <= 1'b0;
         dn_addr    <= '0;
         dn_data    <= '0;
         byte_cnt   <= '0;
         mod        <= '0;
         sw         <= SW_DEFAULT;
         core_reset <= 1'b1;
         rom_ok     <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (dl_rise_c) begin
                  if (ioctl_index == IDX_ROM) begin
                     state      <= ROM;
                     byte_cnt   <= '0;
                     core_reset <= 1'b1;
                  end else begin
                     state      <= CFG;
                     core_reset <= 1'b0;
                  end
               end else if ((state == HOLD) && !hold_busy) begin
                  state      <= IDLE;
                  core_reset <= 1'b0;
               end
            end
            ROM: begin
               if (!ioctl_download) begin
                  state  <= HOLD;
                  rom_ok <= (byte_cnt == ROM_LEN);
               end else if (rom_wr_c) begin
                  dn_addr    <= ioctl_addr[15:0];
                  dn_data    <= ioctl_dout;
                  dn_wr      <= 1'b1;
                  ioctl_wait <= 1'b1;
                  state      <= ROM_PEND;
               end
            end
            ROM_PEND: begin
               // A strobe while stalled is dropped; the pending write stays intact.
               if (ioctl_wr) begin
                  proto_err <= 1'b1;
               end
               if (dn_ready) begin
                  byte_cnt   <= cnt_inc_c;
                  dn_wr      <= 1'b0;
                  ioctl_wait <= 1'b0;
                  if (!ioctl_download) begin
                     state  <= HOLD;
                     rom_ok <= (cnt_inc_c == ROM_LEN);
                  end else begin
                     state <= ROM;
                  end
               end
            end
            CFG: begin
               if (!ioctl_download) begin
                  state <= IDLE;
               end else if (ioctl_wr) begin
                  if (ioctl_index == IDX_MOD) begin
                     mod <= ioctl_dout;
                  end else if ((ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == '0)) begin
                     sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               core_reset <= 1'b0;
            end
         endcase
      end
   end

`ifdef DL_CHECKSUM_EN
   logic        rom_start_c;
   logic [15:0] sum_q;

   assign rom_start_c = ((state == IDLE) || (state == HOLD)) && dl_rise_c && (ioctl_index == IDX_ROM);

   // Running sum of bytes accepted by the ROM side, wrapping at 16 bits.
   always_ff @(posedge CLK) begin
      if (RESET || rom_start_c) begin
         sum_q <= '0;
      end else if (accept_c) begin
         sum_q <= sum_q + 16'(dn_data);
      end
   end

   assign rom_sum = sum_q;
`else
   assign rom_sum = '0;
`endif

endmodule

// File: tb/tb_dl_ctrl.sv
// Randomized bench for dl_ctrl against a transaction-level download model.
module tb_dl_ctrl;

   localparam logic [16:0] ROM_LEN = 17'd4;
   localparam int          HOLD    = 20;
`ifdef DL_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic        ioctl_wait;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;
   logic        dn_ready = 1'b1;
   logic [7:0]  mod;
   logic [63:0] sw;
   logic        core_reset;
   logic        rom_ok;
   logic        proto_err;
   logic [15:0] rom_sum;

   dl_ctrl #(.ROM_LEN(ROM_LEN), .HOLD_CYCLES(HOLD)) dut (
      .CLK(CLK), .RESET(RESET), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
      .dn_ready(dn_ready), .mod(mod), .sw(sw), .core_reset(core_reset),
      .rom_ok(rom_ok), .proto_err(proto_err), .rom_sum(rom_sum)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // Reference model: download session flags plus a countdown of remaining hold cycles.
   bit          m_dl, m_rom, m_pend, m_cfg, m_ok, m_err;
   int          m_hold, m_cnt;
   logic [15:0] m_sum, m_addr;
   logic [7:0]  m_data, m_mod;
   logic [63:0] m_sw;

   always @(posedge CLK) begin
      bit rise;
      rise = ioctl_download && !m_dl;
      if (RESET) begin
         m_rom = 0; m_pend = 0; m_cfg = 0; m_ok = 0; m_err = 0;
         m_hold = HOLD; m_cnt = 0; m_sum = 0; m_addr = 0; m_data = 0;
         m_mod = 0; m_sw = 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (m_pend) begin
         if (ioctl_wr) m_err = 1;
         if (dn_ready) begin
            m_pend = 0;
            if (m_cnt < 131071) m_cnt = m_cnt + 1;
            m_sum = m_sum + 16'(m_data);
            if (!ioctl_download) begin
               m_rom = 0; m_hold = HOLD; m_ok = (m_cnt == int'(ROM_LEN));
            end
         end
      end else if (m_rom) begin
         if (!ioctl_download) begin
            m_rom = 0; m_hold = HOLD; m_ok = (m_cnt == int'(ROM_LEN));
         end else if (ioctl_wr && ioctl_index == 8'd0 && int'(ioctl_addr) < int'(ROM_LEN)) begin
            m_pend = 1; m_addr = ioctl_addr[15:0]; m_data = ioctl_dout;
         end
      end else if (m_cfg) begin
         if (!ioctl_download) m_cfg = 0;
         else if (ioctl_wr && ioctl_index == 8'd1) m_mod = ioctl_dout;
         else if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8)
            m_sw[int'(ioctl_addr[2:0]) * 8 +: 8] = ioctl_dout;
      end else begin
         if (rise) begin
            m_hold = 0;
            if (ioctl_index == 8'd0) begin m_rom = 1; m_cnt = 0; m_sum = 0; end
            else m_cfg = 1;
         end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
         end
      end
      m_dl = ioctl_download;
   end

   always @(negedge CLK) begin
      logic        exp_core;
      logic [15:0] exp_sum;
      if (chk_en) begin
         exp_core = m_rom || (m_hold > 0);
         exp_sum  = CK ? m_sum : 16'h0;
         vectors++;
         if (dn_wr !== m_pend || ioctl_wait !== m_pend || dn_addr !== m_addr || dn_data !== m_data ||
             mod !== m_mod || sw !== m_sw || core_reset !== exp_core || rom_ok !== m_ok ||
             proto_err !== m_err || rom_sum !== exp_sum) begin
            miscompares++;
            $display("FAIL cycle t=%0t got/exp: wr=%b/%b wait=%b/%b addr=%h/%h data=%h/%h mod=%h/%h sw=%h/%h core=%b/%b ok=%b/%b err=%b/%b sum=%h/%h",
                     $time, dn_wr, m_pend, ioctl_wait, m_pend, dn_addr, m_addr, dn_data, m_data,
                     mod, m_mod, sw, m_sw, core_reset, exp_core, rom_ok, m_ok, proto_err, m_err,
                     rom_sum, exp_sum);
         end
      end
   end

   // Activity monitors for the directed literal checks.
   int pulses = 0, run = 0, last_run = 0;
   bit wr_prev = 0, core_seen = 0;
   always @(negedge CLK) begin
      if (dn_wr && !wr_prev) pulses++;
      if (dn_wr) run++;
      else if (run > 0) begin last_run = run; run = 0; end
      wr_prev = dn_wr;
      if (core_reset) core_seen = 1;
   end

   // Ready driver: 0 = always ready, 1 = random, 2 = forced from rdy_force.
   int rdy_mode = 0;
   bit rdy_force = 1'b1;
   initial forever begin
      @(negedge CLK);
      dn_ready = (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : (rdy_mode == 0) ? 1'b1 : rdy_force;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (ioctl_wait === 1'b1 && g < 200) begin tick(1); g++; end
      if (g >= 200) chk("wait_timeout", 64'(ioctl_wait), 64'd0);
   endtask

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index = idx; ioctl_download = 1'b1;
      tick(2);
   endtask

   task automatic end_dl();
      ioctl_download = 1'b0;
      tick(1);
   endtask

   task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
      ioctl_index = idx; ioctl_addr = addr; ioctl_dout = data; ioctl_wr = 1'b1;
      tick(1);
      ioctl_wr = 1'b0;
      wait_idle();
      tick(1);
   endtask

   task automatic measure_hold(input string name);
      int hc = 0;
      while (core_reset === 1'b1 && hc < HOLD + 50) begin hc++; tick(1); end
      chk(name, 64'(hc), 64'(HOLD));
   endtask

   initial begin
      int p;
      // Reset state and post-reset hold.
      tick(1); chk_en = 1'b1; tick(2);
      RESET = 1'b0;
      chk("reset_sw", sw, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("reset_mod", 64'(mod), 64'd0);
      chk("reset_dn_wr", 64'(dn_wr), 64'd0);
      measure_hold("reset_hold");

      // Four-byte image, always ready.
      p = pulses;
      start_dl(8'd0);
      wr_byte(8'd0, 25'd0, 8'h11); wr_byte(8'd0, 25'd1, 8'h22);
      wr_byte(8'd0, 25'd2, 8'h33); wr_byte(8'd0, 25'd3, 8'h44);
      end_dl();
      chk("full_rom_ok", 64'(rom_ok), 64'd1);
      chk("full_rom_sum", 64'(rom_sum), CK ? 64'h00AA : 64'h0);
      chk("full_pulses", 64'(pulses - p), 64'd4);
      measure_hold("full_hold");

      // Out-of-range write is dropped.
      start_dl(8'd0);
      wr_byte(8'd0, 25'd0, 8'h01); wr_byte(8'd0, 25'd1, 8'h02);
      p = pulses;
      wr_byte(8'd0, 25'(ROM_LEN), 8'h77);
      chk("oob_no_wr", 64'(pulses - p), 64'd0);
      wr_byte(8'd0, 25'd2, 8'h03); wr_byte(8'd0, 25'd3, 8'h04);
      end_dl();
      chk("oob_rom_ok", 64'(rom_ok), 64'd1);
      measure_hold("oob_hold");

      // Short image.
      start_dl(8'd0);
      wr_byte(8'd0, 25'd0, 8'hA1); wr_byte(8'd0, 25'd1, 8'hA2); wr_byte(8'd0, 25'd2, 8'hA3);
      end_dl();
      chk("short_rom_ok", 64'(rom_ok), 64'd0);
      measure_hold("short_hold");

      // Stalled write with a strobe during the stall.
      start_dl(8'd0);
      rdy_force = 1'b0; rdy_mode = 2;
      ioctl_addr = 25'd0; ioctl_dout = 8'h10; ioctl_wr = 1'b1;
      tick(1);
      ioctl_wr = 1'b0;
      tick(2);
      ioctl_addr = 25'd1; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
      tick(1);
      ioctl_wr = 1'b0;
      tick(2);
      chk("stall_data", 64'(dn_data), 64'h10);
      rdy_force = 1'b1;
      tick(2);
      rdy_mode = 0;
      chk("stall_len", 64'(last_run), 64'd6);
      chk("stall_proto", 64'(proto_err), 64'd1);
      wr_byte(8'd0, 25'd1, 8'h20); wr_byte(8'd0, 25'd2, 8'h30); wr_byte(8'd0, 25'd3, 8'h40);
      end_dl();
      chk("stall_rom_ok", 64'(rom_ok), 64'd1);
      measure_hold("stall_hold");

      // Config download: DIP byte and variant byte.
      core_seen = 0;
      start_dl(8'd254);
      wr_byte(8'd254, 25'd2, 8'h5A);
      wr_byte(8'd254, 25'd9, 8'h33);
      wr_byte(8'd1, 25'd0, 8'h05);
      wr_byte(8'd7, 25'd0, 8'hEE);
      end_dl();
      tick(1);
      chk("cfg_sw", sw, 64'hFFFF_FFFF_FF5A_FFFF);
      chk("cfg_mod", 64'(mod), 64'd5);
      chk("cfg_core_seen", 64'(core_seen), 64'd0);

      // Reset while a write is pending.
      start_dl(8'd0);
      rdy_force = 1'b0; rdy_mode = 2;
      ioctl_addr = 25'd0; ioctl_dout = 8'h42; ioctl_wr = 1'b1;
      tick(1);
      ioctl_wr = 1'b0;
      tick(2);
      RESET = 1'b1; ioctl_download = 1'b0;
      tick(1);
      chk("rst_dn_wr", 64'(dn_wr), 64'd0);
      chk("rst_sw", sw, 64'hFFFF_FFFF_FFFF_FFFF);
      tick(1);
      RESET = 1'b0; rdy_mode = 0;
      measure_hold("rst_hold");

      // Randomized sessions.
      for (int it = 0; it < 150; it++) begin
         logic [7:0] idx;
         int sel, nb;
         sel = int'($urandom_range(0, 5));
         idx = (sel < 3) ? 8'd0 : (sel == 3) ? 8'd1 : (sel == 4) ? 8'd254 : 8'd9;
         rdy_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
         start_dl(idx);
         nb = int'($urandom_range(0, 6));
         for (int b = 0; b < nb; b++) begin
            logic [24:0] a;
            logic [7:0]  ci;
            a = ($urandom_range(0, 7) == 0) ? 25'h100_0008 : 25'($urandom_range(0, 9));
            ci = (idx == 8'd0) ? 8'd0 : ($urandom_range(0, 1) ? 8'd1 : 8'd254);
            if (idx == 8'd0 && $urandom_range(0, 4) == 0) begin
               ioctl_index = ci; ioctl_addr = a; ioctl_dout = 8'($urandom); ioctl_wr = 1'b1;
               tick(2);
               ioctl_wr = 1'b0;
               wait_idle();
               tick(1);
            end else begin
               wr_byte(ci, a, 8'($urandom));
            end
         end
         if (idx == 8'd0 && $urandom_range(0, 3) == 0) begin
            ioctl_addr = 25'($urandom_range(0, 3)); ioctl_dout = 8'($urandom); ioctl_wr = 1'b1;
            tick(1);
            ioctl_wr = 1'b0;
         end
         end_dl();
         if ($urandom_range(0, 19) == 0) begin
            RESET = 1'b1; tick(2); RESET = 1'b0;
         end
         tick(int'($urandom_range(1, HOLD + 5)));
      end
      rdy_mode = 0;
      tick(HOLD + 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dl_ctrl.md
DL_CTRL -- requirements
Module: dl_ctrl

Interface
REQ-001 SHALL have parameter ROM_LEN, default 17'h10000, meaning the expected ROM image length in bytes; legal range 1..65536, so it is 17 bits wide.
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024, meaning the number of core-reset hold cycles after a download or after RESET.
REQ-003 SHALL have port CLK, in, 1, the system clock; one clock only.
REQ-004 SHALL have port RESET, in, 1, a synchronous active-high reset.
REQ-005 SHALL have port ioctl_download, in, 1, high while a download is active.
REQ-006 SHALL have port ioctl_wr, in, 1, a one-cycle byte strobe.
REQ-007 SHALL have port ioctl_index, in, 8, the download target index.
REQ-008 SHALL have port ioctl_addr, in, 25, the byte address.
REQ-009 SHALL have port ioctl_dout, in, 8, the byte data.
REQ-010 SHALL have port ioctl_wait, out, 1, the stall request back to the loader.
REQ-011 SHALL have port dn_addr, out, 16, the ROM write address.
REQ-012 SHALL have port dn_data, out, 8, the ROM write data.
REQ-013 SHALL have port dn_wr, out, 1, the ROM write request.
REQ-014 SHALL have port dn_ready, in, 1, the ROM side accepting dn_wr in the current cycle.
REQ-015 SHALL have port mod, out, 8, the game-variant byte.
REQ-016 SHALL have port sw, out, 64, the DIP bytes, byte n at bits [8n+7:8n].
REQ-017 SHALL have port core_reset, out, 1, the reset request to the game core.
REQ-018 SHALL have port rom_ok, out, 1, meaning the last ROM download was exactly ROM_LEN bytes.
REQ-019 SHALL have port proto_err, out, 1, a sticky loader protocol violation flag.
REQ-020 SHALL have port rom_sum, out, 16, the ROM byte checksum (see Configuration).

Function
REQ-021 SHALL implement FSM states IDLE, ROM, ROM_PEND, CFG, HOLD.
REQ-022 SHALL leave IDLE as follows: when ioctl_download rises with index 0, go to ROM and clear the byte counter and rom_sum; with any other index, go to CFG.
REQ-023 SHALL handle an index-0 write in ROM with addr < ROM_LEN by registering addr[15:0] and data, and asserting dn_wr and ioctl_wait on the next cycle (latency 1); the state then becomes ROM_PEND.
REQ-024 SHALL, in ROM_PEND, hold dn_wr, dn_addr and dn_data stable until dn_ready is sampled high.
REQ-025 SHALL, on the cycle dn_ready is sampled high in ROM_PEND, increment the counter, update rom_sum, and drop dn_wr and ioctl_wait on the following cycle, returning to ROM.
REQ-026 SHALL drop an index-0 write with addr >= ROM_LEN silently: no dn_wr and no count.
REQ-027 SHALL treat ioctl_wr arriving in ROM_PEND as a protocol violation: set proto_err, discard the byte, and leave the pending write unaffected.
REQ-028 SHALL, in CFG, latch mod <= dout on an index-1 write at any address, last write wins.
REQ-029 SHALL, in CFG, latch sw byte addr[2:0] <= dout on an index-254 write with addr[24:3] == 0.
REQ-030 SHALL, in CFG, ignore all other indices; ioctl_wait SHALL stay 0 in CFG.
REQ-031 SHALL, when ioctl_download falls in ROM, go to HOLD and set rom_ok = (count == ROM_LEN).
REQ-032 SHALL, when ioctl_download falls in ROM_PEND, first complete the pending write, then go to HOLD with the count including that byte.
REQ-033 SHALL, when ioctl_download falls in CFG, return to IDLE with no hold and leave core_reset unaffected.
REQ-034 SHALL, in HOLD, count HOLD_CYCLES cycles and then go to IDLE; a new download start in HOLD SHALL restart the FSM from the IDLE transition rules.
REQ-035 SHALL assert core_reset in states ROM, ROM_PEND and HOLD, and deassert it otherwise.
REQ-036 SHALL wrap rom_sum modulo 2^16 and saturate the byte counter at 2^17-1.

Reset
REQ-037 SHALL, on RESET, clear dn_wr, ioctl_wait, rom_ok, proto_err and rom_sum, and set mod = 0 and sw = all ones.
REQ-038 SHALL, on RESET, enter HOLD with core_reset = 1 for HOLD_CYCLES cycles after RESET deasserts.
REQ-039 SHALL abandon any in-flight write when RESET is applied mid-download, with dn_wr going low on the next cycle.

Configuration
REQ-040 SHALL, with macro DL_CHECKSUM_EN defined, have rom_sum equal the 16-bit sum of accepted ROM bytes.
REQ-041 SHALL, without DL_CHECKSUM_EN defined, tie rom_sum to 0 and build no adder.

Structure
REQ-042 SHALL place the FSM state enum, the constants IDX_ROM = 0, IDX_MOD = 1, IDX_DIP = 254 and SW_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF in the shared package dl_pkg.
REQ-043 SHALL implement the HOLD counter as sub-module dl_hold_timer (inputs start and len, output busy).

Verification
REQ-044 SHALL cover: ROM_LEN=4, index 0, bytes 11,22,33,44 to addresses 0-3 with dn_ready always 1 -> four dn_wr pulses, each one cycle after its ioctl_wr; rom_ok=1; rom_sum=0x00AA.
REQ-045 SHALL cover: dn_ready held low for 5 cycles on byte 0 -> dn_wr and ioctl_wait high for 6 cycles with dn_addr/dn_data stable; a second ioctl_wr during that window -> proto_err=1 and count unchanged.
REQ-046 SHALL cover: ROM_LEN=4, three bytes written, then ioctl_download falls -> rom_ok=0 and core_reset high for exactly HOLD_CYCLES cycles after the fall.
REQ-047 SHALL cover: index 254, addr 2, data 0x5A, then index 1, data 0x05 -> sw = 64'hFFFF_FFFF_FF5A_FFFF, mod = 5, core_reset never asserted.
REQ-048 SHALL cover: RESET during ROM_PEND -> dn_wr = 0 on the next cycle, sw = all ones, core_reset high for HOLD_CYCLES cycles after RESET deasserts.
REQ-049 SHALL cover: an index-0 write at addr = ROM_LEN -> no dn_wr and counter unchanged.
